// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clk_meter period/duty/phase monitor.
package clk_meter_pkg;

    localparam int unsigned DEFAULT_CNT_W = 16;
    localparam int unsigned SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StHigh = 2'd2,
        StLow  = 2'd3
    } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous input into clk and emits one-cycle rise/fall pulses.
module sync_edge
    import clk_meter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/clk_meter.sv
// Recovers period, high time and phase (vs. ref_in) of sig_in as clk cycle counts.
module clk_meter
    import clk_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEFAULT_CNT_W,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    input  logic             ref_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic [CNT_W-1:0] phase_o,
    output logic             phase_ok_o,
    output logic             meas_valid_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             w_sig_rise;
    logic             w_sig_fall;
    logic             w_ref_rise;
    logic             w_ref_fall_unused;
    meter_state_e     r_state;
    meter_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] w_per_nxt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] w_hi_nxt;
    logic [CNT_W-1:0] r_ph_cnt;
    logic [CNT_W-1:0] w_ph_inc;
    logic [CNT_W-1:0] w_ph_cap;
    logic             w_publish;
    logic             w_to_set;
    logic             w_meas_on;

    sync_edge u_sig_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sig_in),
        .o_rise  (w_sig_rise),
        .o_fall  (w_sig_fall)
    );

    sync_edge u_ref_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (ref_in),
        .o_rise  (w_ref_rise),
        .o_fall  (w_ref_fall_unused)
    );

    assign w_meas_on = en && (r_state != StIdle);
    assign w_ph_inc  = (r_ph_cnt == CNT_MAX) ? r_ph_cnt : r_ph_cnt + 1'b1;
    // A coincident ref rise makes the phase of this sig rise exactly zero.
    assign w_ph_cap  = w_ref_rise ? '0 : w_ph_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_per_nxt   = r_per_cnt;
        w_hi_nxt    = r_hi_cnt;
        w_publish   = 1'b0;
        w_to_set    = 1'b0;
        if (!en) begin
            w_state_nxt = StIdle;
            w_per_nxt   = '0;
            w_hi_nxt    = '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_nxt = StArm;
                    w_per_nxt   = '0;
                    w_hi_nxt    = '0;
                end
                StArm: begin
                    if (w_sig_rise) begin
                        w_state_nxt = StHigh;
                        w_per_nxt   = CNT_W'(1);
                    end else if (r_per_cnt >= TO_VAL) begin
                        w_to_set  = 1'b1;
                        w_per_nxt = '0;
                    end else begin
                        w_per_nxt = r_per_cnt + 1'b1;
                    end
                end
                StHigh: begin
                    // Timeout outranks the fall so the counter can never pass TO_VAL.
                    if (w_sig_rise) begin
                        w_per_nxt = CNT_W'(1);
                    end else if (r_per_cnt >= TO_VAL) begin
                        w_to_set    = 1'b1;
                        w_state_nxt = StArm;
                        w_per_nxt   = '0;
                    end else if (w_sig_fall) begin
                        w_hi_nxt    = r_per_cnt;
                        w_state_nxt = StLow;
                        w_per_nxt   = r_per_cnt + 1'b1;
                    end else begin
                        w_per_nxt = r_per_cnt + 1'b1;
                    end
                end
                StLow: begin
                    if (w_sig_rise) begin
                        w_publish   = 1'b1;
                        w_state_nxt = StHigh;
                        w_per_nxt   = CNT_W'(1);
                    end else if (r_per_cnt >= TO_VAL) begin
                        w_to_set    = 1'b1;
                        w_state_nxt = StArm;
                        w_per_nxt   = '0;
                    end else begin
                        w_per_nxt = r_per_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_per_nxt   = '0;
                    w_hi_nxt    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_per_cnt <= w_per_nxt;
            r_hi_cnt  <= w_hi_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ph_cnt   <= '0;
            phase_ok_o <= 1'b0;
        end else if (!w_meas_on) begin
            r_ph_cnt   <= '0;
            phase_ok_o <= 1'b0;
        end else begin
            r_ph_cnt <= w_ph_cap;
            if (w_ref_rise) begin
                phase_ok_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_o     <= '0;
            high_o       <= '0;
            phase_o      <= '0;
            meas_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            meas_valid_o <= w_publish;
            if (w_publish) begin
                period_o <= r_per_cnt;
                high_o   <= r_hi_cnt;
                phase_o  <= w_ph_cap;
            end
            if (!en || w_publish) begin
                timeout_o <= 1'b0;
            end else if (w_to_set) begin
                timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_meter.sv
// Scoreboard bench for clk_meter: directed waveforms push expected packets, a monitor pops them.
module tb_clk_meter;
    import clk_meter_pkg::*;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 100;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             sig_in;
    logic             ref_in;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic [CNT_W-1:0] phase_o;
    logic             phase_ok_o;
    logic             meas_valid_o;
    logic             timeout_o;

    typedef struct {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] ph;
        logic             ok;
        bit               chk_ph;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   ignore_valid = 1'b0;

    clk_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sig_in       (sig_in),
        .ref_in       (ref_in),
        .period_o     (period_o),
        .high_o       (high_o),
        .phase_o      (phase_o),
        .phase_ok_o   (phase_ok_o),
        .meas_valid_o (meas_valid_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void push(input int per, input int hi, input int ph, input bit ok,
                                 input bit chk_ph);
        exp_t e;
        e.per    = CNT_W'(per);
        e.hi     = CNT_W'(hi);
        e.ph     = CNT_W'(ph);
        e.ok     = ok;
        e.chk_ph = chk_ph;
        sb_q.push_back(e);
    endfunction

    // Monitor: every valid pulse must match the oldest expected packet.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && meas_valid_o === 1'b1 && !ignore_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_valid: got period %0d high %0d phase %0d, none expected",
                         period_o, high_o, phase_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (period_o !== e.per || high_o !== e.hi || phase_ok_o !== e.ok ||
                    (e.chk_ph && phase_o !== e.ph)) begin
                    n_errors++;
                    $display("FAIL meas: got per %0d hi %0d ph %0d ok %0b, expected per %0d hi %0d ph %0d ok %0b",
                             period_o, high_o, phase_o, phase_ok_o, e.per, e.hi, e.ph, e.ok);
                end
            end
        end
    end

    // One step per clk cycle; sig_in lags ref_in by ph cycles.
    task automatic run_wave(input int per, input int hi, input int ph, input int nper,
                            input bit drive_ref);
        for (int t = 0; t < nper * per; t++) begin
            int d;
            @(negedge clk);
            d = t - ph;
            sig_in = (d >= 0) && ((d % per) < hi);
            if (drive_ref) ref_in = (t % per) < (per / 2);
        end
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic rearm();
        @(negedge clk);
        en     = 1'b0;
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"}, 32'(period_o), 32'd0);
        check({tag, "_high"}, 32'(high_o), 32'd0);
        check({tag, "_phase"}, 32'(phase_o), 32'd0);
        check({tag, "_phase_ok"}, 32'(phase_ok_o), 32'd0);
        check({tag, "_valid"}, 32'(meas_valid_o), 32'd0);
        check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        check("reset_state", 32'(dut.r_state), 32'(StIdle));
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);

        // Period 10, high 3, no reference: first rise only arms.
        repeat (4) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 5, 1'b0);
        drain("drain_basic");
        rearm();

        // Phase offset 4 against a 10-cycle reference.
        repeat (3) push(10, 3, 4, 1'b1, 1'b1);
        run_wave(10, 3, 4, 4, 1'b1);
        drain("drain_phase4");
        rearm();

        // Phase offset 0: coincident rises.
        repeat (3) push(10, 3, 0, 1'b1, 1'b1);
        run_wave(10, 3, 0, 4, 1'b1);
        drain("drain_phase0");
        rearm();

        // Timeout after the signal stops, then recovery.
        repeat (2) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 3, 1'b0);
        repeat (120) @(negedge clk);
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_state", 32'(dut.r_state), 32'(StArm));
        check("to_period_hold", 32'(period_o), 32'd10);
        check("to_high_hold", 32'(high_o), 32'd3);
        check("to_no_valid", 32'(sb_q.size()), 32'd0);
        repeat (2) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 3, 1'b0);
        drain("drain_to_resume");
        check("to_cleared", 32'(timeout_o), 32'd0);
        rearm();

        // Enable drop while in HIGH.
        repeat (2) push(10, 5, 0, 1'b1, 1'b1);
        run_wave(10, 5, 0, 2, 1'b1);
        @(negedge clk);
        sig_in = 1'b1;
        ref_in = 1'b1;
        repeat (5) @(negedge clk);
        check("en_pre_state", 32'(dut.r_state), 32'(StHigh));
        check("en_pre_phase_ok", 32'(phase_ok_o), 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_state", 32'(dut.r_state), 32'(StIdle));
        check("en_timeout", 32'(timeout_o), 32'd0);
        check("en_phase_ok", 32'(phase_ok_o), 32'd0);
        check("en_valid", 32'(meas_valid_o), 32'd0);
        check("en_period_hold", 32'(period_o), 32'd10);
        check("en_queue", 32'(sb_q.size()), 32'd0);
        en     = 1'b1;
        sig_in = 1'b0;
        ref_in = 1'b0;
        repeat (5) @(negedge clk);
        repeat (2) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 3, 1'b0);
        drain("drain_en_resume");
        rearm();

        // Asynchronous reset while in LOW.
        push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 2, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        check("midrst_state", 32'(dut.r_state), 32'(StIdle));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        repeat (2) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 3, 1'b0);
        drain("drain_post_reset");
        rearm();

        // Minimum signal: high 2, low 2.
        repeat (4) push(4, 2, 0, 1'b0, 1'b0);
        run_wave(4, 2, 0, 5, 1'b0);
        drain("drain_min");
        rearm();

        // Random glitches must not wedge the state machine.
        ignore_valid = 1'b1;
        repeat (300) begin
            @(negedge clk);
            sig_in = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        sig_in = 1'b0;
        repeat (5) @(negedge clk);
        run_wave(10, 3, 0, 1, 1'b0);
        ignore_valid = 1'b0;
        repeat (3) push(10, 3, 0, 1'b0, 1'b0);
        run_wave(10, 3, 0, 3, 1'b0);
        drain("drain_glitch");
        check("glitch_timeout", 32'(timeout_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_meter.md
# clk_meter

Measures an externally generated clock or pulse train (`sig_in`) against the system clock `clk` and reports period, high time and phase offset relative to a second reference signal (`ref_in`). It is the checking end of the testbench clock generator: the generator produces frequency, duty cycle and phase, and this block recovers them as cycle counts. The block is synthesizable and also serves as a self-checking monitor in benches.

## Interface

Parameters:
- `CNT_W`, 16: width of all measurement counters and outputs.
- `TIMEOUT`, 1000: cycles without a `sig_in` edge before `timeout_o` asserts. Must be less than 2^CNT_W.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: measurement enable; low forces IDLE.
- `sig_in` in 1: asynchronous measured signal.
- `ref_in` in 1: asynchronous phase reference.
- `period_o` out CNT_W: cycles between consecutive `sig_in` rising edges.
- `high_o` out CNT_W: cycles from a `sig_in` rise to the following fall.
- `phase_o` out CNT_W: cycles from the latest `ref_in` rise to the `sig_in` rise.
- `phase_ok_o` out 1: `phase_o` is meaningful, meaning a `ref_in` rise has been seen since the last IDLE.
- `meas_valid_o` out 1: one-cycle pulse when the outputs update.
- `timeout_o` out 1: sticky no-activity flag.

## Operation

- Both inputs pass through a 2-flop synchronizer, then an edge-detect flop. An edge is reported 3 `clk` cycles after the input transition.
- State machine: IDLE, ARM, HIGH, LOW.
  - IDLE: counters are held at 0. When `en`=1, go to ARM.
  - ARM: wait for a `sig_in` rise, then go to HIGH with `per_cnt`=1.
  - HIGH: `per_cnt` increments each cycle. On a `sig_in` fall, latch `hi_cnt`=`per_cnt` and go to LOW.
  - LOW: `per_cnt` increments. On a `sig_in` rise:
    - publish `period_o`=`per_cnt`, `high_o`=`hi_cnt`, `phase_o`=captured phase;
    - pulse `meas_valid_o`;
    - clear `timeout_o`;
    - restart with `per_cnt`=1 and stay in HIGH.
  - A rise seen in HIGH, meaning a missed fall, discards the measurement. Stay in HIGH with `per_cnt`=1 and raise no valid pulse.
- Phase counter: reset to 0 on a `ref_in` rise, otherwise incrementing and saturating at 2^CNT_W-1. On each `sig_in` rise, capture its value. If both rises occur in the same cycle, the captured phase is 0.
- Timeout: in ARM, HIGH or LOW, if `per_cnt` (or the ARM wait count) reaches TIMEOUT:
  - set `timeout_o`=1;
  - go to ARM;
  - leave the published outputs unchanged.
- `en` falling in any state goes to IDLE on the next cycle. This clears `timeout_o` and `phase_ok_o` but leaves the published values unchanged.
- Minimum measurable signal: high ≥2 and low ≥2 `clk` cycles. Shorter pulses give undefined results but must not hang the state machine.

## Timing

- Reset values: all outputs 0; state IDLE; synchronizers 0.
- Output latency: `meas_valid_o` pulses 3 cycles after the `sig_in` rise that completes a period. Outputs are registered and stable until the next pulse.
- The first valid measurement comes at the second `sig_in` rise after ARM.
- Reset asserted mid-measurement clears everything immediately, asynchronously.
- Counters in HIGH/LOW never wrap, because timeout fires first.

## Structure

- `clk_meter_pkg` holds:
  - the state enum `meter_state_e` (IDLE, ARM, HIGH, LOW);
  - the default `CNT_W`;
  - the sync stage-count constant `SYNC_STAGES`=2.
- Sub-module `sync_edge`: synchronizer plus rise/fall pulse outputs, instantiated once for `sig_in` and once for `ref_in`.

## Test plan

- Period and duty: `sig_in` period 10 cycles, high 3, `en`=1. The second and every later rise gives `period_o`=10, `high_o`=3, with one `meas_valid_o` pulse per period.
- Phase: `ref_in` period 10, `sig_in` the same period delayed 4 cycles. Expect `phase_o`=4 and `phase_ok_o`=1. With the delay set to 0, expect `phase_o`=0.
- Timeout: stop `sig_in` after a valid measurement. After TIMEOUT cycles `timeout_o`=1, state ARM, outputs hold the old values. When the signal resumes, the second rise clears `timeout_o`.
- Enable drop: deassert `en` mid-HIGH. Next cycle: IDLE, `timeout_o`=0, `phase_ok_o`=0, no pulse. Re-enable, and the first valid pulse comes at the second rise.
- Reset mid-operation: pulse `rst_n` low during LOW. All outputs read 0 immediately, and measurement restarts correctly afterwards.
- Minimum signal: high 2, low 2 gives `period_o`=4, `high_o`=2. Random 1-cycle glitches must never deadlock the block.
